// File: rtl/clk_wave_pkg.sv
// Shared types for the clk_wave_sched waveform scheduler: FSM states, default widths
// and the stored interval configuration.
package clk_wave_pkg;
  localparam int CNT_W_DEF = 16;
  localparam int PER_W_DEF = 16;

  typedef enum logic [1:0] {IDLE, PHASE, HIGH, LOW} state_t;

  typedef struct packed {
    logic [CNT_W_DEF-1:0] phase;
    logic [CNT_W_DEF-1:0] ton;
    logic [CNT_W_DEF-1:0] toff;
  } cfg_t;

  localparam cfg_t CFG_RST = '{phase: '0, ton: CNT_W_DEF'(1), toff: CNT_W_DEF'(1)};
endpackage

// File: rtl/wave_dcnt.sv
// Loadable down-counter with zero flag, shared by the phase, high and low intervals.
module wave_dcnt #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         ld_i,
  input  logic [W-1:0] val_i,
  input  logic         dec_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q;

  // Datapath register: always loaded before first use, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (ld_i)       cnt_q <= val_i;
    else if (dec_i) cnt_q <= cnt_q - W'(1);
  end

  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/clk_wave_sched.sv
// Programmable waveform scheduler: phase delay, then alternating high/low intervals.
// Optional burst mode (period limit plus done pulse) is enabled by defining CLK_WAVE_BURST_EN.
module clk_wave_sched
  import clk_wave_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int PER_W = PER_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_phase,
  input  logic [CNT_W-1:0] cfg_ton,
  input  logic [CNT_W-1:0] cfg_toff,
  output logic             cfg_err,
`ifdef CLK_WAVE_BURST_EN
  input  logic [PER_W-1:0] cfg_nper,
  output logic             done,
`endif
  input  logic             start,
  input  logic             stop,
  output logic             wave,
  output logic             rise,
  output logic             fall,
  output logic             busy,
  output logic [PER_W-1:0] periods
);
  state_t           state_q, state_d;
  cfg_t             cfg_q;
  logic [PER_W-1:0] per_q, per_d;
  logic             pend_q, pend_d;
  logic             wave_q, rise_q, fall_q, busy_q, cfg_ready_q, cfg_err_q;
  logic             cnt_ld, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_val;
  logic             cfg_acc, cfg_bad, stop_now;
`ifdef CLK_WAVE_BURST_EN
  logic [PER_W-1:0] nper_q;
  logic             done_q, done_d;
`endif

  assign cfg_acc  = cfg_valid && cfg_ready_q;
  assign cfg_bad  = (cfg_ton == '0) || (cfg_toff == '0);
  assign stop_now = stop || pend_q;

  wave_dcnt #(.W(CNT_W)) u_dcnt (
    .clk_i  (clk),
    .ld_i   (cnt_ld),
    .val_i  (cnt_val),
    .dec_i  (cnt_dec),
    .zero_o (cnt_zero)
  );

  always_comb begin
    state_d = state_q;
    per_d   = per_q;
    pend_d  = pend_q || stop;
    cnt_ld  = 1'b0;
    cnt_dec = 1'b0;
    cnt_val = '0;
`ifdef CLK_WAVE_BURST_EN
    done_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          per_d  = '0;
          cnt_ld = 1'b1;
          if (cfg_q.phase != '0) begin
            state_d = PHASE;
            cnt_val = cfg_q.phase - CNT_W'(1);
          end else begin
            state_d = HIGH;
            cnt_val = cfg_q.ton - CNT_W'(1);
          end
        end
      end
      PHASE: begin
        if (stop_now) begin
          state_d = IDLE;
        end else if (cnt_zero) begin
          state_d = HIGH;
          cnt_ld  = 1'b1;
          cnt_val = cfg_q.ton - CNT_W'(1);
        end else begin
          cnt_dec = 1'b1;
        end
      end
      // A stop seen in HIGH is only honoured once the pulse has run its full length.
      HIGH: begin
        if (cnt_zero) begin
          state_d = LOW;
          cnt_ld  = 1'b1;
          cnt_val = cfg_q.toff - CNT_W'(1);
        end else begin
          cnt_dec = 1'b1;
        end
      end
      LOW: begin
        if (stop_now) begin
          state_d = IDLE;
        end else if (cnt_zero) begin
          per_d   = per_q + PER_W'(1);
          state_d = HIGH;
          cnt_ld  = 1'b1;
          cnt_val = cfg_q.ton - CNT_W'(1);
`ifdef CLK_WAVE_BURST_EN
          if ((nper_q != '0) && (per_d == nper_q)) begin
            state_d = IDLE;
            cnt_ld  = 1'b0;
            done_d  = 1'b1;
          end
`endif
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE) pend_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cfg_q       <= CFG_RST;
      per_q       <= '0;
      pend_q      <= 1'b0;
      wave_q      <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      busy_q      <= 1'b0;
      cfg_ready_q <= 1'b1;
      cfg_err_q   <= 1'b0;
`ifdef CLK_WAVE_BURST_EN
      nper_q      <= '0;
      done_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      per_q       <= per_d;
      pend_q      <= pend_d;
      wave_q      <= (state_d == HIGH);
      rise_q      <= (state_d == HIGH) && (state_q != HIGH);
      fall_q      <= (state_d == LOW) && (state_q != LOW);
      busy_q      <= (state_d != IDLE);
      cfg_ready_q <= (state_d == IDLE);
      cfg_err_q   <= cfg_acc && cfg_bad;
      if (cfg_acc && !cfg_bad) begin
        cfg_q <= '{phase: cfg_phase, ton: cfg_ton, toff: cfg_toff};
`ifdef CLK_WAVE_BURST_EN
        nper_q <= cfg_nper;
`endif
      end
`ifdef CLK_WAVE_BURST_EN
      done_q <= done_d;
`endif
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign cfg_err   = cfg_err_q;
  assign wave      = wave_q;
  assign rise      = rise_q;
  assign fall      = fall_q;
  assign busy      = busy_q;
  assign periods   = per_q;
`ifdef CLK_WAVE_BURST_EN
  assign done      = done_q;
`endif
endmodule

// File: tb/tb_clk_wave_sched.sv
// Directed bench for clk_wave_sched: expected per-cycle outputs are queued as stimulus is
// driven and popped against the DUT just after each rising edge.
module tb_clk_wave_sched;
  localparam int CW = 16;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_valid = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [CW-1:0] cfg_phase = '0;
  logic [CW-1:0] cfg_ton = '0;
  logic [CW-1:0] cfg_toff = '0;
  logic          cfg_ready, cfg_err, wave, rise, fall, busy;
  logic [PW-1:0] periods;
`ifdef CLK_WAVE_BURST_EN
  logic [PW-1:0] cfg_nper = '0;
  logic          done;
`endif

  typedef struct packed {
    logic          wave;
    logic          rise;
    logic          fall;
    logic          busy;
    logic          done;
    logic [PW-1:0] periods;
  } exp_t;

  exp_t  sb[$];
  int    n_chk = 0;
  int    n_pass = 0;
  int    n_fail = 0;
  string cur = "init";

  clk_wave_sched #(.CNT_W(CW), .PER_W(PW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_phase (cfg_phase),
    .cfg_ton   (cfg_ton),
    .cfg_toff  (cfg_toff),
    .cfg_err   (cfg_err),
`ifdef CLK_WAVE_BURST_EN
    .cfg_nper  (cfg_nper),
    .done      (done),
`endif
    .start     (start),
    .stop      (stop),
    .wave      (wave),
    .rise      (rise),
    .fall      (fall),
    .busy      (busy),
    .periods   (periods)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
    n_chk++;
    assert (got === want) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s.%s: got %0d expected %0d", cur, tag, got, want);
    end
  endtask

  // Cycle i counts from 1 = the cycle right after the edge that sampled start.
  function automatic exp_t model(int ph, int on, int off, int i);
    exp_t e;
    int   j, per, r;
    e      = '0;
    e.busy = 1'b1;
    if (i <= ph) return e;
    j         = i - ph - 1;
    per       = on + off;
    r         = j % per;
    e.wave    = (r < on);
    e.rise    = (r == 0);
    e.fall    = (r == on);
    e.periods = PW'(j / per);
    return e;
  endfunction

  function automatic exp_t idle_e(int per, logic dn);
    exp_t e;
    e         = '0;
    e.periods = PW'(per);
    e.done    = dn;
    return e;
  endfunction

  task automatic cyc();
    exp_t e;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("wave", 32'(wave), 32'(e.wave));
    chk("rise", 32'(rise), 32'(e.rise));
    chk("fall", 32'(fall), 32'(e.fall));
    chk("busy", 32'(busy), 32'(e.busy));
    chk("periods", 32'(periods), 32'(e.periods));
    chk("cfg_ready", 32'(cfg_ready), 32'(!e.busy));
    chk("cfg_err", 32'(cfg_err), 32'(0));
`ifdef CLK_WAVE_BURST_EN
    chk("done", 32'(done), 32'(e.done));
`endif
  endtask

  task automatic load_cfg(int ph, int on, int off, logic want_err);
    cfg_valid = 1'b1;
    cfg_phase = CW'(ph);
    cfg_ton   = CW'(on);
    cfg_toff  = CW'(off);
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    chk("cfg_err_pulse", 32'(cfg_err), 32'(want_err));
  endtask

  task automatic run_span(int ph, int on, int off, int i0, int i1);
    for (int i = i0; i <= i1; i++) begin
      sb.push_back(model(ph, on, off, i));
      cyc();
      start = 1'b0;
    end
  endtask

  initial begin
    cur = "reset";
    repeat (2) @(posedge clk);
    #1;
    sb.push_back(idle_e(0, 1'b0));
    cyc();
    rst = 1'b0;

    // Phase 7, 5/5: first high 8 cycles after start; stop lands on 2nd HIGH cycle.
    cur = "p7_t5_t5";
    load_cfg(7, 5, 5, 1'b0);
    start = 1'b1;
    run_span(7, 5, 5, 1, 39);
    cur = "stop_in_high";
    stop = 1'b1;
    run_span(7, 5, 5, 40, 40);
    stop = 1'b0;
    run_span(7, 5, 5, 41, 43);
    sb.push_back(idle_e(3, 1'b0));
    cyc();
    sb.push_back(idle_e(3, 1'b0));
    cyc();

    // Phase 0, 1/3 duty; stop on the final LOW cycle must not count the period.
    cur = "p0_t1_t3";
    load_cfg(0, 1, 3, 1'b0);
    start = 1'b1;
    run_span(0, 1, 3, 1, 12);
    cur = "stop_end_low";
    stop = 1'b1;
    sb.push_back(idle_e(2, 1'b0));
    cyc();
    stop = 1'b0;

    // Rejected configs pulse cfg_err once and leave 0/1/3 in place.
    cur = "cfg_bad";
    load_cfg(5, 0, 3, 1'b1);
    sb.push_back(idle_e(2, 1'b0));
    cyc();
    load_cfg(5, 3, 0, 1'b1);
    sb.push_back(idle_e(2, 1'b0));
    cyc();
    cur = "old_cfg";
    start = 1'b1;
    run_span(0, 1, 3, 1, 2);
    cur = "cfg_while_busy";
    cfg_valid = 1'b1;
    cfg_phase = CW'(3);
    cfg_ton   = CW'(2);
    cfg_toff  = CW'(2);
    stop = 1'b1;
    sb.push_back(idle_e(0, 1'b0));
    cyc();
    cfg_valid = 1'b0;
    stop = 1'b0;
    cur = "cfg_kept";
    start = 1'b1;
    run_span(0, 1, 3, 1, 5);
    stop = 1'b1;
    run_span(0, 1, 3, 6, 6);
    stop = 1'b0;
    sb.push_back(idle_e(1, 1'b0));
    cyc();

    cur = "stop_in_phase";
    load_cfg(4, 2, 2, 1'b0);
    start = 1'b1;
    run_span(4, 2, 2, 1, 1);
    stop = 1'b1;
    sb.push_back(idle_e(0, 1'b0));
    cyc();
    stop = 1'b0;
    sb.push_back(idle_e(0, 1'b0));
    cyc();

    cur = "start_and_stop";
    start = 1'b1;
    stop  = 1'b1;
    sb.push_back(idle_e(0, 1'b0));
    cyc();
    start = 1'b0;
    stop  = 1'b0;
    sb.push_back(idle_e(0, 1'b0));
    cyc();

    // Reset during HIGH aborts at once and restores the 0/1/1 default config.
    cur = "rst_in_high";
    load_cfg(0, 3, 2, 1'b0);
    start = 1'b1;
    run_span(0, 3, 2, 1, 12);
    rst = 1'b1;
    sb.push_back(idle_e(0, 1'b0));
    cyc();
    rst = 1'b0;
    sb.push_back(idle_e(0, 1'b0));
    cyc();
    cur = "default_cfg";
    start = 1'b1;
    run_span(0, 1, 1, 1, 4);
    stop = 1'b1;
    sb.push_back(idle_e(1, 1'b0));
    cyc();
    stop = 1'b0;

`ifdef CLK_WAVE_BURST_EN
    cur = "burst2";
    cfg_nper = PW'(2);
    load_cfg(0, 2, 2, 1'b0);
    cfg_nper = '0;
    start = 1'b1;
    run_span(0, 2, 2, 1, 8);
    sb.push_back(idle_e(2, 1'b1));
    cyc();
    sb.push_back(idle_e(2, 1'b0));
    cyc();
    sb.push_back(idle_e(2, 1'b0));
    cyc();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/clk_wave_sched.md
Name: clk_wave_sched

Overview:
- Synthesizable, programmable waveform scheduler that produces a derived clock-like output inside the single `clk` domain.
- Output is a clock enable/waveform, not a true clock.
- Software/bench loads phase delay, high time and low time in `clk` cycles, then starts and stops generation through a handshake.
- Sits beside the 100 MHz system clock and provides gated/derived timing strobes to downstream datapaths.

Parameters:
CNT_W, 16, width of phase/ton/toff fields and internal down-counter
PER_W, 16, width of completed-period counter

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
cfg_valid  input  1  config offered
cfg_ready  output  1  config accepted when cfg_valid&&cfg_ready
cfg_phase  input  CNT_W  cycles before first high (0 = none)
cfg_ton  input  CNT_W  high cycles (must be >=1)
cfg_toff  input  CNT_W  low cycles (must be >=1)
cfg_err  output  1  one-cycle pulse: offered config rejected
start  input  1  begin generation (level sampled, acted on in IDLE)
stop  input  1  request end of generation
wave  output  1  generated waveform
rise  output  1  one-cycle pulse on cycle wave first goes 1
fall  output  1  one-cycle pulse on cycle wave first goes 0
busy  output  1  state != IDLE
periods  output  PER_W  completed high+low periods since start, wraps

Behaviour:
- Reset (sync, rst=1 at posedge) values:
  - state=IDLE; wave, rise, fall, busy, cfg_err = 0; periods = 0.
  - Stored config = phase 0, ton 1, toff 1; cfg_ready = 1.
  - Reset mid-operation aborts immediately with no trailing fall pulse.
- Config handshake:
  - cfg_ready = 1 only in IDLE.
  - On accept, if cfg_ton==0 or cfg_toff==0: config is discarded, cfg_err pulses next cycle, prior config is retained.
  - Otherwise the config is latched.
- States are IDLE, PHASE, HIGH, LOW. All outputs are registered.
- IDLE:
  - start=1 && stop=0: clear periods; go to PHASE if phase>0 (counter=phase-1), else HIGH (counter=ton-1).
  - start && stop together: stay IDLE.
  - cfg accept and start in the same cycle: start uses the previously stored config.
- PHASE: wave=0; count down; at counter==0 go to HIGH.
- HIGH:
  - wave=1 for exactly ton cycles; rise asserted the first HIGH cycle.
  - At counter==0 go to LOW (counter=toff-1).
- LOW:
  - wave=0 for exactly toff cycles; fall asserted the first LOW cycle.
  - At counter==0: periods+1 (modulo 2^PER_W); go to HIGH.
- Latency: first wave=1 cycle is phase+1 cycles after the cycle start is sampled in IDLE.
- Stop:
  - stop is latched as pending (sticky until IDLE).
  - In PHASE or LOW: go to IDLE next cycle. An in-progress LOW period does not increment periods.
  - In HIGH: the high pulse completes (no runt). Then go to LOW for one cycle (fall pulses, periods not incremented), then IDLE.
  - start is ignored while busy.

Optional Feature:
- Macro: CLK_WAVE_BURST_EN.
- Defined:
  - Extra input cfg_nper [PER_W] is latched with config; 0 means free-running.
  - Extra output done: one-cycle pulse.
  - When periods reaches cfg_nper at the end of a LOW, go to IDLE, pulse done, and hold periods.
- Undefined:
  - No cfg_nper or done ports.
  - Generation runs until stop or rst.

Decomposition:
- Package clk_wave_pkg holds:
  - typedef enum logic [1:0] {IDLE, PHASE, HIGH, LOW} state_t;
  - default CNT_W/PER_W localparams;
  - a packed cfg_t struct {phase, ton, toff}.
- One sub-module is natural: wave_dcnt, a loadable down-counter with zero flag, reused for all three intervals.

Test Plan:
- Load phase=7, ton=5, toff=5, start: wave rises 8 cycles after start and toggles every 5 cycles (period 10). rise/fall pulse once per edge. periods=3 after 30 cycles of HIGH/LOW.
- phase=0, ton=1, toff=3: first wave=1 the cycle after start; wave duty is 1 of 4; periods increments every 4 cycles.
- Offer cfg_ton=0: cfg_err pulses once; old config is still used on the next start. cfg_ready=0 while busy, so cfg_valid is not accepted.
- stop asserted on the 2nd cycle of a ton=5 HIGH: wave stays high 5 cycles total, then 1 LOW cycle with fall, then busy=0. stop in PHASE: busy=0 next cycle with no rise.
- rst asserted during HIGH: next cycle wave=0, busy=0, periods=0, no fall pulse. start+stop together in IDLE: stays IDLE.
- With CLK_WAVE_BURST_EN and cfg_nper=2, ton=2, toff=2: exactly 2 high pulses, done pulses the cycle after the 2nd LOW ends, periods holds 2.
